// File: rtl/fwrisc_dbus_pkg.sv
// Shared types and constants for the fwrisc data-bus responder.
// Consumed by fwrisc_dbus_rsp and fwrisc_dbus_ram.
package fwrisc_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    TURN
  } dbus_state_e;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STB_W     = 4;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned WCNT_W    = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [DATA_W-1:0] ERR_DATA  = 32'h0;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fwrisc_dbus_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
// Read data is registered and returns ERR_DATA on cycles without a read.
module fwrisc_dbus_ram
  import fwrisc_dbus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [STB_W-1:0]      wstb,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; contents are intentionally not reset
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < int'(STB_W); i++) begin
        if (wstb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)   rdata <= ERR_DATA;
    else if (re) rdata <= mem[addr];
    else         rdata <= ERR_DATA;
  end

endmodule

// File: rtl/fwrisc_dbus_rsp.sv
// fwrisc data-bus responder: one request at a time, RAM-backed, with wait states
// and a sticky out-of-range error. Define FWRISC_DBUS_RSP_JITTER_EN for LFSR wait jitter.
module fwrisc_dbus_rsp
  import fwrisc_dbus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dvalid,
  input  logic [31:0]       daddr,
  input  logic              dwrite,
  input  logic [31:0]       dwdata,
  input  logic [3:0]        dwstb,
  output logic [31:0]       drdata,
  output logic              dready,
  output logic              err,
  output logic [31:0]       err_addr,
  input  logic              err_clr
);

  localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

  dbus_state_e             state, state_nxt;
  logic [WCNT_W-1:0]       wcnt, wcnt_nxt;
  logic [WCNT_W-1:0]       wait_cnt_c;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [ADDR_WIDTH-1:0]   req_idx_c;
  logic [ADDR_WIDTH-1:0]   ram_addr_c;
  logic                    ld_q;
  logic                    in_range_c;
  logic                    accept_c;
  logic                    ram_we_c;
  logic                    ram_re_c;
  logic                    unused_c;

  assign unused_c   = ^daddr[1:0];
  assign in_range_c = (daddr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign req_idx_c  = daddr[TAG_LSB-1:2];
  assign accept_c   = (state == IDLE) && dvalid;

`ifdef FWRISC_DBUS_RSP_JITTER_EN
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset)         lfsr <= LFSR_SEED;
    else if (accept_c) lfsr <= lfsr_next(lfsr);
  end

  assign wait_cnt_c = WCNT_W'(WAIT_STATES) + WCNT_W'(lfsr[1:0]);
`else
  assign wait_cnt_c = WCNT_W'(WAIT_STATES);
`endif

  // Next-state and wait counter
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: begin
        if (dvalid) begin
          wcnt_nxt  = wait_cnt_c;
          state_nxt = (wait_cnt_c != '0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        wcnt_nxt = wcnt - WCNT_W'(1);
        if (wcnt <= WCNT_W'(1)) state_nxt = ACK;
      end
      ACK:     state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      wcnt   <= '0;
      idx_q  <= '0;
      ld_q   <= 1'b0;
      dready <= 1'b0;
    end else begin
      state  <= state_nxt;
      wcnt   <= wcnt_nxt;
      dready <= (state_nxt == ACK);
      if (accept_c) begin
        idx_q <= req_idx_c;
        ld_q  <= !dwrite && in_range_c;
      end
    end
  end

  // Stores commit at accept; the read is issued on the edge entering ACK so it lands in drdata
  assign ram_addr_c = (state == IDLE) ? req_idx_c : idx_q;
  assign ram_we_c   = !reset && accept_c && dwrite && in_range_c;
  assign ram_re_c   = (state_nxt == ACK) &&
                      ((state == IDLE) ? (!dwrite && in_range_c) : ld_q);

  fwrisc_dbus_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .addr  (ram_addr_c),
    .we    (ram_we_c),
    .wstb  (dwstb),
    .wdata (dwdata),
    .re    (ram_re_c),
    .rdata (drdata)
  );

  // A new out-of-range accept overrides a same-cycle clear
  always_ff @(posedge clock) begin
    if (reset) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (accept_c && !in_range_c) begin
      err <= 1'b1;
      if (!err || err_clr) err_addr <= daddr;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_fwrisc_dbus_rsp.sv
// Directed bench for fwrisc_dbus_rsp: three instances with WAIT_STATES 0, 3 and 5.
// Expected latencies include LFSR jitter when FWRISC_DBUS_RSP_JITTER_EN is defined.
module tb_fwrisc_dbus_rsp;

  logic        clock;
  logic        reset;
  logic        dvalid_r   [3];
  logic [31:0] daddr;
  logic        dwrite;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic        err_clr;
  logic [31:0] drdata_w   [3];
  logic        dready_w   [3];
  logic        err_w      [3];
  logic [31:0] err_addr_w [3];

  int unsigned ws [3] = '{0, 3, 5};
  logic [15:0] lf_m [3];
  int n_chk  = 0;
  int n_pass = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  fwrisc_dbus_rsp #(.WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset(reset), .dvalid(dvalid_r[0]), .daddr(daddr), .dwrite(dwrite),
    .dwdata(dwdata), .dwstb(dwstb), .drdata(drdata_w[0]), .dready(dready_w[0]),
    .err(err_w[0]), .err_addr(err_addr_w[0]), .err_clr(err_clr));

  fwrisc_dbus_rsp #(.WAIT_STATES(3)) u_dut3 (
    .clock(clock), .reset(reset), .dvalid(dvalid_r[1]), .daddr(daddr), .dwrite(dwrite),
    .dwdata(dwdata), .dwstb(dwstb), .drdata(drdata_w[1]), .dready(dready_w[1]),
    .err(err_w[1]), .err_addr(err_addr_w[1]), .err_clr(err_clr));

  fwrisc_dbus_rsp #(.WAIT_STATES(5)) u_dut5 (
    .clock(clock), .reset(reset), .dvalid(dvalid_r[2]), .daddr(daddr), .dwrite(dwrite),
    .dwdata(dwdata), .dwstb(dwstb), .drdata(drdata_w[2]), .dready(dready_w[2]),
    .err(err_w[2]), .err_addr(err_addr_w[2]), .err_clr(err_clr));

  function automatic logic [15:0] lf_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Expected accept-to-dready latency for instance k; advances the model LFSR
  function automatic int exp_latency(input int k);
    int l;
    l = 1 + int'(ws[k]);
`ifdef FWRISC_DBUS_RSP_JITTER_EN
    l = l + int'(lf_m[k][1:0]);
`endif
    lf_m[k] = lf_next(lf_m[k]);
    return l;
  endfunction

  // One request on instance k; returns on the negedge of the TURN cycle
  task automatic req(input int k, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                     input logic [3:0] sb, input logic clr, input logic chk_rd,
                     input logic [31:0] exp_rd, input string tag);
    int exp_lat;
    int lat;
    logic [31:0] rd;
    bit seen;
    @(negedge clock);
    daddr = a; dwrite = wr; dwdata = wd; dwstb = sb; err_clr = clr;
    dvalid_r[k] = 1'b1;
    exp_lat = exp_latency(k);
    seen = 1'b0; lat = 0; rd = '0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clock);
      err_clr = 1'b0;
      if (dready_w[k]) begin
        seen = 1'b1; lat = c; rd = drdata_w[k];
      end
    end
    dvalid_r[k] = 1'b0;
    check($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
    if (chk_rd) check($sformatf("%s.drdata", tag), rd, exp_rd);
    @(negedge clock);
    check($sformatf("%s.pulse_width", tag), {31'b0, dready_w[k]}, 32'h0);
  endtask

  task automatic reseed();
    for (int i = 0; i < 3; i++) lf_m[i] = 16'hACE1;
  endtask

  initial begin
    int hits;
    reset = 1'b1; daddr = '0; dwrite = 1'b0; dwdata = '0; dwstb = '0; err_clr = 1'b0;
    for (int i = 0; i < 3; i++) dvalid_r[i] = 1'b0;
    reseed();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst.dready0", {31'b0, dready_w[0]}, 32'h0);
    check("rst.dready3", {31'b0, dready_w[1]}, 32'h0);
    check("rst.drdata0", drdata_w[0], 32'h0);
    check("rst.err0",    {31'b0, err_w[0]}, 32'h0);
    check("rst.erraddr0", err_addr_w[0], 32'h0);

    // Full-word store then load, zero wait states
    req(0, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'h0, "t1.store");
    req(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1234_5678, "t1.load");
    check("t1.err", {31'b0, err_w[0]}, 32'h0);

    // Byte strobes, and an all-zero strobe store
    req(0, 32'h8000_0020, 1'b1, 32'hAABB_CCDD, 4'hF, 1'b0, 1'b0, 32'h0, "t2.preload");
    req(0, 32'h8000_0020, 1'b1, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, 32'h0, "t2.bytes");
    req(0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hAA22_CC44, "t2.load");
    req(0, 32'h8000_0020, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, 32'h0, "t2.nostb");
    req(0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hAA22_CC44, "t2.reload");
    req(0, 32'h8000_0100, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0, "t2.alias");

    // Three wait states
    req(1, 32'h8000_0040, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 32'h0, "t3.store");
    req(1, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, "t3.load");

    // Out-of-range accesses and the sticky error register
    req(0, 32'h0000_0100, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0, "t4.oor_store");
    check("t4.err_set", {31'b0, err_w[0]}, 32'h1);
    check("t4.err_addr", err_addr_w[0], 32'h0000_0100);
    req(0, 32'h9000_0000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, "t4.oor_load");
    check("t4.err_addr_first", err_addr_w[0], 32'h0000_0100);
    req(0, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, "t4.no_write");
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    check("t4.clr_err", {31'b0, err_w[0]}, 32'h0);
    check("t4.clr_addr", err_addr_w[0], 32'h0);
    req(0, 32'h0000_0300, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, "t4.oor2");
    check("t4.err_addr2", err_addr_w[0], 32'h0000_0300);
    req(0, 32'h0000_0400, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, "t4.clr_race");
    check("t4.race_err", {31'b0, err_w[0]}, 32'h1);
    check("t4.race_addr", err_addr_w[0], 32'h0000_0400);

    // Reset two cycles into a five-wait-state load
    req(2, 32'h8000_0080, 1'b1, 32'h5555_AAAA, 4'hF, 1'b0, 1'b0, 32'h0, "t5.store");
    @(negedge clock);
    daddr = 32'h8000_0080; dwrite = 1'b0; dwstb = 4'h0; dvalid_r[2] = 1'b1;
    hits = 0;
    @(negedge clock);
    if (dready_w[2]) hits++;
    @(negedge clock);
    if (dready_w[2]) hits++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; dvalid_r[2] = 1'b0;
    reseed();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (dready_w[2]) hits++;
    end
    check("t5.dropped", 32'(hits), 32'h0);
    check("t5.err_reset", {31'b0, err_w[0]}, 32'h0);
    req(2, 32'h8000_0080, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5555_AAAA, "t5.after");

    // Back-to-back loads; latency tracks the reference LFSR when jitter is on
    for (int i = 0; i < 16; i++)
      req(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1234_5678,
          $sformatf("t6.load%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
